amo_mem_responder: RTL and testbench
====================================

// Module: amo_mem_responder
// PURPOSE
//  Memory-side responder for the AMO unit's amo_mem_s request interface. Owns a word-addressed
//  data RAM shared with the LSU port and returns read data one cycle after a read request.
//  Holds an atomicity lock from an AMO read until the matching AMO write, stalling the LSU meanwhile.
//  Sits between the AMO unit / LSU and the data memory.
// PARAMETERS
//  DEPTH        1024  number of 32-bit words in the data RAM (power of two)
//  LOCK_TIMEOUT 15    max cycles a lock may be held awaiting the AMO write before forced release
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   asynchronous reset, active-high
//  amo_req_i     in   70  amo_mem_s {wr_en, rd_en, addr[31:0], mask[3:0], data[31:0]} from AMO unit
//  amo_rvalid_o  out  1   AMO read data valid (one cycle pulse)
//  amo_rdata_o   out  32  AMO read data
//  lsu_rd_en_i   in   1   LSU load request
//  lsu_wr_en_i   in   1   LSU store request
//  lsu_addr_i    in   32  LSU byte address
//  lsu_mask_i    in   4   LSU byte-write mask
//  lsu_wdata_i   in   32  LSU store data
//  lsu_stall_o   out  1   LSU request not accepted this cycle; LSU must hold request
//  lsu_rvalid_o  out  1   LSU read data valid (one cycle pulse)
//  lsu_rdata_o   out  32  LSU read data
//  lock_err_o    out  1   sticky: lock timed out or AMO write address mismatched lock
// BEHAVIOUR
//  - Reset (async, rst=1): state=R_IDLE, lock addr=0, timeout counter=0, all *_rvalid_o=0,
//    *_rdata_o=0, lsu_stall_o=0, lock_err_o=0. RAM contents are not reset.
//  - Word index = addr[2 +: $clog2(DEPTH)]; addr[1:0] and upper bits ignored.
//  - Writes: byte lane i updated iff mask[i]; write takes effect at the clock edge of the request.
//  - Reads: data registered; rvalid and rdata appear exactly 1 cycle after the accepted request.
//    rdata holds its last value when rvalid=0.
//  - AMO request with both rd_en and wr_en set: write performed, read ignored.
//  - Arbitration: AMO port has absolute priority. LSU stalled (lsu_stall_o=1, combinational)
//    whenever an AMO request is present this cycle or state=R_LOCKED. LSU rd+wr both set:
//    write only.
//  - Same-cycle read-after-write to the same word is impossible (single port); a read the cycle
//    after a write returns the new data.
//  - FSM:
//    R_IDLE   : AMO rd_en -> latch lock addr (word index), counter=0, go R_LOCKED.
//               AMO wr_en alone -> plain write, stay R_IDLE.
//    R_LOCKED : AMO wr_en -> perform write, go R_IDLE (lock released the same edge; LSU may be
//               accepted next cycle). If write word index != lock addr, write still performed
//               and lock_err_o set.
//               AMO rd_en only -> re-latch lock addr, counter=0, stay R_LOCKED.
//               No AMO request -> counter+1; when counter reaches LOCK_TIMEOUT, go R_IDLE and
//               set lock_err_o.
//  - lock_err_o clears only on reset.
//  - Reset mid-lock: lock dropped, pending rvalid suppressed, LSU unstalled immediately.
// TESTING
//  1 reset; LSU store addr 0x10 data 0xDEADBEEF mask 4'hF, then LSU load 0x10 -> lsu_rvalid_o=1
//    one cycle later, lsu_rdata_o=0xDEADBEEF, lsu_stall_o=0 throughout.
//  2 word 0x20=0x11223344; LSU store mask 4'b0010 data 0x0000AA00 -> read returns 0x1122AA44.
//  3 AMO rd 0x20, LSU load held high -> amo_rvalid_o next cycle with 0x1122AA44; lsu_stall_o=1
//    until cycle after AMO wr 0x20 data 0x5; LSU then reads 0x00000005.
//  4 AMO rd 0x40, no write for LOCK_TIMEOUT cycles -> state R_IDLE, lock_err_o=1 sticky,
//    lsu_stall_o drops.
//  5 AMO rd 0x40 then AMO wr 0x44 -> word 0x44 written, lock released, lock_err_o=1.
//  6 AMO rd in flight, assert rst for 1 cycle -> amo_rvalid_o=0, lsu_stall_o=0, lock_err_o=0
//    immediately (async).

Source files
------------

// File: rtl/amo_mem_responder.sv
// Memory-side responder for the AMO unit: a word-addressed data RAM shared with the LSU,
// with an AMO read-to-write atomicity lock that stalls the LSU and can time out.
module amo_mem_responder #(
  parameter int DEPTH        = 1024,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [69:0] amo_req_i,
  output logic        amo_rvalid_o,
  output logic [31:0] amo_rdata_o,
  input  logic        lsu_rd_en_i,
  input  logic        lsu_wr_en_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [3:0]  lsu_mask_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lock_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(LOCK_TIMEOUT);

  typedef enum logic {
    R_IDLE,
    R_LOCKED
  } state_e;

  logic        amo_wr;
  logic        amo_rd;
  logic        amo_valid;
  logic [31:0] amo_addr;
  logic [3:0]  amo_mask;
  logic [31:0] amo_data;
  logic [AW-1:0] amo_idx;
  logic [AW-1:0] lsu_idx;

  assign amo_wr    = amo_req_i[69];
  assign amo_rd    = amo_req_i[68];
  assign amo_addr  = amo_req_i[67:36];
  assign amo_mask  = amo_req_i[35:32];
  assign amo_data  = amo_req_i[31:0];
  assign amo_valid = amo_wr | amo_rd;
  assign amo_idx   = amo_addr[2 +: AW];
  assign lsu_idx   = lsu_addr_i[2 +: AW];

  // Byte offset and out-of-range upper address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{amo_addr[31:AW+2], amo_addr[1:0],
                              lsu_addr_i[31:AW+2], lsu_addr_i[1:0]};

  logic [31:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] lock_addr_q, lock_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          amo_rvalid_q, amo_rvalid_d;
  logic [31:0]   amo_rdata_q, amo_rdata_d;
  logic          lsu_rvalid_q, lsu_rvalid_d;
  logic [31:0]   lsu_rdata_q, lsu_rdata_d;

  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [3:0]    mem_mask;
  logic [31:0]   mem_wdata;
  logic [31:0]   rd_word;
  logic [CW-1:0] cnt_inc;
  logic          amo_rd_fire;
  logic          lsu_rd_fire;
  logic          lsu_stall;

  always_comb begin
    state_d     = state_q;
    lock_addr_d = lock_addr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    mem_idx     = lsu_idx;
    mem_mask    = lsu_mask_i;
    mem_wdata   = lsu_wdata_i;
    amo_rd_fire = 1'b0;
    lsu_rd_fire = 1'b0;
    cnt_inc     = cnt_q + CW'(1);
    lsu_stall   = amo_valid | (state_q == R_LOCKED);

    if (amo_valid) begin
      mem_idx   = amo_idx;
      mem_mask  = amo_mask;
      mem_wdata = amo_data;
      // A write always wins over a simultaneous read and always releases the lock.
      if (amo_wr) begin
        mem_we  = 1'b1;
        state_d = R_IDLE;
        if (state_q == R_LOCKED && amo_idx != lock_addr_q) begin
          err_d = 1'b1;
        end
      end else begin
        amo_rd_fire = 1'b1;
        lock_addr_d = amo_idx;
        cnt_d       = '0;
        state_d     = R_LOCKED;
      end
    end else if (state_q == R_LOCKED) begin
      cnt_d = cnt_inc;
      if (cnt_inc == TIMEOUT_VAL) begin
        state_d = R_IDLE;
        err_d   = 1'b1;
      end
    end else if (lsu_wr_en_i) begin
      mem_we = 1'b1;
    end else if (lsu_rd_en_i) begin
      lsu_rd_fire = 1'b1;
    end

    rd_word      = mem[mem_idx];
    amo_rvalid_d = amo_rd_fire;
    lsu_rvalid_d = lsu_rd_fire;
    amo_rdata_d  = amo_rd_fire ? rd_word : amo_rdata_q;
    lsu_rdata_d  = lsu_rd_fire ? rd_word : lsu_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) begin
          mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= R_IDLE;
      lock_addr_q  <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      amo_rvalid_q <= 1'b0;
      amo_rdata_q  <= '0;
      lsu_rvalid_q <= 1'b0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lock_addr_q  <= lock_addr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      amo_rvalid_q <= amo_rvalid_d;
      amo_rdata_q  <= amo_rdata_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign amo_rvalid_o = amo_rvalid_q;
  assign amo_rdata_o  = amo_rdata_q;
  assign lsu_rvalid_o = lsu_rvalid_q;
  assign lsu_rdata_o  = lsu_rdata_q;
  assign lsu_stall_o  = lsu_stall;
  assign lock_err_o   = err_q;

endmodule

// File: tb/tb_amo_mem_responder.sv
// Scoreboard bench for amo_mem_responder: a reference memory predicts every read, expected
// read data is queued when a read is driven and popped when the matching rvalid pulse shows up.
module tb_amo_mem_responder;

   localparam int LockTimeout = 15;

   logic        clk;
   logic        rst;
   logic [69:0] amoReq;
   logic        amoRvalid;
   logic [31:0] amoRdata;
   logic        lsuRdEn;
   logic        lsuWrEn;
   logic [31:0] lsuAddr;
   logic [3:0]  lsuMask;
   logic [31:0] lsuWdata;
   logic        lsuStall;
   logic        lsuRvalid;
   logic [31:0] lsuRdata;
   logic        lockErr;

   int checkCount = 0;
   int errorCount = 0;

   logic [31:0] refMem [1024];
   logic [31:0] expAmo [$];
   logic [31:0] expLsu [$];

   amo_mem_responder #(
      .DEPTH(1024),
      .LOCK_TIMEOUT(LockTimeout)
   ) dut (
      .clk(clk),
      .rst(rst),
      .amo_req_i(amoReq),
      .amo_rvalid_o(amoRvalid),
      .amo_rdata_o(amoRdata),
      .lsu_rd_en_i(lsuRdEn),
      .lsu_wr_en_i(lsuWrEn),
      .lsu_addr_i(lsuAddr),
      .lsu_mask_i(lsuMask),
      .lsu_wdata_i(lsuWdata),
      .lsu_stall_o(lsuStall),
      .lsu_rvalid_o(lsuRvalid),
      .lsu_rdata_o(lsuRdata),
      .lock_err_o(lockErr)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the stimulus ever stops advancing.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord, input logic [31:0] newWord,
                                              input logic [3:0] mask);
      logic [31:0] res;
      res = oldWord;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) res[8*b +: 8] = newWord[8*b +: 8];
      end
      return res;
   endfunction

   function automatic int wordIdx(input logic [31:0] addr);
      return int'(addr[11:2]);
   endfunction

   // Drives one cycle of requests (called at posedge+1), checks the combinational stall,
   // updates the reference memory / read queues for accepted requests, then advances a cycle.
   task automatic applyStimulus(input string tag,
                                input logic amoWr, input logic amoRd, input logic [31:0] amoAddr,
                                input logic [3:0] amoMask, input logic [31:0] amoData,
                                input logic lsuWr, input logic lsuRd, input logic [31:0] lAddr,
                                input logic [3:0] lMask, input logic [31:0] lData,
                                input logic expStall);
      amoReq   = {amoWr, amoRd, amoAddr, amoMask, amoData};
      lsuWrEn  = lsuWr;
      lsuRdEn  = lsuRd;
      lsuAddr  = lAddr;
      lsuMask  = lMask;
      lsuWdata = lData;
      #1;
      checkOutput({tag, "_stall"}, {31'd0, lsuStall}, {31'd0, expStall});
      if (amoWr) begin
         refMem[wordIdx(amoAddr)] = mergeBytes(refMem[wordIdx(amoAddr)], amoData, amoMask);
      end else if (amoRd) begin
         expAmo.push_back(refMem[wordIdx(amoAddr)]);
      end
      if (!expStall) begin
         if (lsuWr) begin
            refMem[wordIdx(lAddr)] = mergeBytes(refMem[wordIdx(lAddr)], lData, lMask);
         end else if (lsuRd) begin
            expLsu.push_back(refMem[wordIdx(lAddr)]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic lsuStore(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
      applyStimulus(tag, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, addr, mask, data, 1'b0);
   endtask

   task automatic lsuLoad(input string tag, input logic [31:0] addr, input logic expStall);
      applyStimulus(tag, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b1, addr, 4'd0, 32'd0, expStall);
   endtask

   task automatic idleCycle(input string tag, input logic expStall);
      applyStimulus(tag, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, expStall);
   endtask

   // Scoreboard consumer: every rvalid pulse must match the oldest outstanding expected read.
   always @(negedge clk) begin
      if (!rst) begin
         if (amoRvalid) begin
            if (expAmo.size() == 0) checkOutput("amo_spurious_rvalid", {31'd0, amoRvalid}, 32'd0);
            else checkOutput("amo_rdata", amoRdata, expAmo.pop_front());
         end
         if (lsuRvalid) begin
            if (expLsu.size() == 0) checkOutput("lsu_spurious_rvalid", {31'd0, lsuRvalid}, 32'd0);
            else checkOutput("lsu_rdata", lsuRdata, expLsu.pop_front());
         end
      end
   end

   initial begin
      rst      = 1'b1;
      amoReq   = '0;
      lsuRdEn  = 1'b0;
      lsuWrEn  = 1'b0;
      lsuAddr  = '0;
      lsuMask  = '0;
      lsuWdata = '0;
      #1;
      checkOutput("rst_amo_rvalid", {31'd0, amoRvalid}, 32'd0);
      checkOutput("rst_amo_rdata", amoRdata, 32'd0);
      checkOutput("rst_lsu_rvalid", {31'd0, lsuRvalid}, 32'd0);
      checkOutput("rst_lsu_rdata", lsuRdata, 32'd0);
      checkOutput("rst_stall", {31'd0, lsuStall}, 32'd0);
      checkOutput("rst_lock_err", {31'd0, lockErr}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Plain LSU store then load; read data must hold afterwards.
      lsuStore("t1_store", 32'h10, 32'hDEADBEEF, 4'hF);
      lsuLoad("t1_load", 32'h10, 1'b0);
      idleCycle("t1_idle0", 1'b0);
      idleCycle("t1_idle1", 1'b0);
      checkOutput("t1_hold", lsuRdata, 32'hDEADBEEF);

      // Byte-masked store.
      lsuStore("t2_init", 32'h20, 32'h11223344, 4'hF);
      lsuStore("t2_mask", 32'h20, 32'h0000AA00, 4'b0010);
      lsuLoad("t2_load", 32'h20, 1'b0);
      idleCycle("t2_idle", 1'b0);

      // AMO read locks out a held LSU load until the cycle after the AMO write.
      applyStimulus("t3_amo_rd", 1'b0, 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 1'b1, 32'h20, 4'h0, 32'h0, 1'b1);
      lsuLoad("t3_locked0", 32'h20, 1'b1);
      lsuLoad("t3_locked1", 32'h20, 1'b1);
      applyStimulus("t3_amo_wr", 1'b1, 1'b0, 32'h20, 4'hF, 32'h5, 1'b0, 1'b1, 32'h20, 4'h0, 32'h0, 1'b1);
      lsuLoad("t3_released", 32'h20, 1'b0);
      idleCycle("t3_idle", 1'b0);
      checkOutput("t3_amo_hold", amoRdata, 32'h1122AA44);
      checkOutput("t3_lock_err", {31'd0, lockErr}, 32'd0);

      // Lock timeout with no AMO write: stall for exactly LockTimeout cycles, sticky error.
      lsuStore("t4_init", 32'h40, 32'hCAFEF00D, 4'hF);
      applyStimulus("t4_amo_rd", 1'b0, 1'b1, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      for (int i = 1; i <= LockTimeout; i++) begin
         lsuLoad("t4_wait", 32'h10, 1'b1);
         checkOutput("t4_lock_err", {31'd0, lockErr}, (i == LockTimeout) ? 32'd1 : 32'd0);
      end
      lsuLoad("t4_after", 32'h10, 1'b0);
      idleCycle("t4_idle0", 1'b0);
      idleCycle("t4_idle1", 1'b0);
      checkOutput("t4_sticky", {31'd0, lockErr}, 32'd1);

      // Asynchronous reset with an AMO read response in flight and the lock held.
      amoReq = {1'b0, 1'b1, 32'h10, 4'h0, 32'h0};
      #1;
      checkOutput("t6_stall_pre", {31'd0, lsuStall}, 32'd1);
      @(posedge clk);
      #1;
      amoReq = '0;
      rst    = 1'b1;
      #1;
      checkOutput("t6_amo_rvalid", {31'd0, amoRvalid}, 32'd0);
      checkOutput("t6_amo_rdata", amoRdata, 32'd0);
      checkOutput("t6_stall", {31'd0, lsuStall}, 32'd0);
      checkOutput("t6_lock_err", {31'd0, lockErr}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // AMO write to a different word than the lock: write lands, lock released, error set.
      applyStimulus("t5_amo_rd", 1'b0, 1'b1, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      checkOutput("t5_err_pre", {31'd0, lockErr}, 32'd0);
      applyStimulus("t5_amo_wr", 1'b1, 1'b0, 32'h44, 4'hF, 32'h12345678, 1'b0, 1'b1, 32'h44, 4'h0, 32'h0, 1'b1);
      checkOutput("t5_lock_err", {31'd0, lockErr}, 32'd1);
      lsuLoad("t5_load44", 32'h44, 1'b0);
      lsuLoad("t5_load40", 32'h40, 1'b0);
      idleCycle("t5_idle0", 1'b0);
      idleCycle("t5_idle1", 1'b0);

      checkOutput("amo_pending", 32'(expAmo.size()), 32'd0);
      checkOutput("lsu_pending", 32'(expLsu.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
